// File: rtl/mb8_pkg.sv
// Shared constants and types for the three-requester byte-memory arbiter.
package mb8_pkg;
  localparam int MB8_ASZ  = 17;
  localparam int MB8_DSZ  = 8;
  localparam int MB8_NREQ = 3;

  localparam int REQ_CONSOLE = 0;
  localparam int REQ_FINDER  = 1;
  localparam int REQ_INNER   = 2;

  typedef enum logic [1:0] {IDLE, OPEN, LOCK} arb_state_e;
endpackage

// File: rtl/mb8_io.sv
// Single-port byte memory bus; the arbiter is the only master.
interface mb8_io #(
  parameter int ASZ = mb8_pkg::MB8_ASZ,
  parameter int DSZ = mb8_pkg::MB8_DSZ
);
  logic           we;
  logic [ASZ-1:0] addr;
  logic [DSZ-1:0] wdata;
  logic [DSZ-1:0] rdata;

  modport master (output we, addr, wdata, input rdata);
  modport slave  (input we, addr, wdata, output rdata);
endinterface

// File: rtl/rr_pick.sv
// One-hot winner picker: round-robin from ptr, or lowest index when
// MB8_ARB_FIXED_PRI_EN is defined (ptr port then absent).
module rr_pick #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
`ifndef MB8_ARB_FIXED_PRI_EN
  input  logic [PW-1:0] ptr,
`endif
  output logic [N-1:0]  win
);
`ifdef MB8_ARB_FIXED_PRI_EN
  always_comb begin
    win = '0;
    for (int i = 0; i < N; i++)
      if (req[i] && win == '0) win[i] = 1'b1;
  end
`else
  int idx;

  always_comb begin
    win = '0;
    idx = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (req[idx] && win == '0) win[idx] = 1'b1;
    end
  end
`endif
endmodule

// File: rtl/mb8_arb.sv
// Arbiter for the spram8_128k port: round-robin (or fixed priority under
// MB8_ARB_FIXED_PRI_EN) with per-requester bus lock; grant issues the access.
module mb8_arb
  import mb8_pkg::*;
#(
  parameter int ASZ  = MB8_ASZ,
  parameter int DSZ  = MB8_DSZ,
  parameter int NREQ = MB8_NREQ
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ-1:0]           lock,
  input  logic [NREQ-1:0]           we,
  input  logic [NREQ-1:0][ASZ-1:0]  ai,
  input  logic [NREQ-1:0][DSZ-1:0]  vi,
  output logic [NREQ-1:0]           gnt,
  output logic [NREQ-1:0]           ack,
  output logic [DSZ-1:0]            vo,
  mb8_io.master                     mb_if
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e      state_q, state_d;
  logic [PW-1:0]   owner_q, owner_d, win_idx;
  logic [NREQ-1:0] ack_q, owner_oh, others, arb_req, win;
  logic            hold;
  logic            mwe;
  logic [ASZ-1:0]  maddr;
  logic [DSZ-1:0]  mwd;
`ifndef MB8_ARB_FIXED_PRI_EN
  logic [PW-1:0]   ptr_q, ptr_d;
`endif

  // On lock release the old owner yields if anyone else is waiting.
  always_comb begin
    owner_oh          = '0;
    owner_oh[owner_q] = 1'b1;
    others            = req & ~owner_oh;
    hold              = (state_q == LOCK) && lock[owner_q];
    arb_req           = ((state_q == LOCK) && (others != '0)) ? others : req;
  end

  rr_pick #(.N(NREQ), .PW(PW)) u_pick (
    .req (arb_req),
`ifndef MB8_ARB_FIXED_PRI_EN
    .ptr (ptr_q),
`endif
    .win (win)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NREQ; i++)
      if (win[i]) win_idx = PW'(i);
    gnt     = '0;
    state_d = state_q;
    owner_d = owner_q;
`ifndef MB8_ARB_FIXED_PRI_EN
    ptr_d   = ptr_q;
`endif
    if (!rst) begin
      gnt = '0;
    end else if (hold) begin
      // Locked bus stays reserved for the owner even when it is not asking.
      gnt = req & owner_oh;
    end else if (win != '0) begin
      gnt     = win;
      owner_d = win_idx;
      state_d = lock[win_idx] ? LOCK : OPEN;
`ifndef MB8_ARB_FIXED_PRI_EN
      ptr_d   = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
`endif
    end else begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      ack_q   <= '0;
`ifndef MB8_ARB_FIXED_PRI_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ack_q   <= gnt;
`ifndef MB8_ARB_FIXED_PRI_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  always_comb begin
    mwe   = 1'b0;
    maddr = '0;
    mwd   = '0;
    for (int i = 0; i < NREQ; i++)
      if (gnt[i]) begin
        mwe   = mwe | we[i];
        maddr = maddr | ai[i];
        mwd   = mwd | vi[i];
      end
  end

  assign mb_if.we    = mwe;
  assign mb_if.addr  = maddr;
  assign mb_if.wdata = mwd;
  assign ack         = ack_q;
  // Read data is forced to zero outside an ack so the bus reads quiet in reset.
  assign vo          = (ack_q != '0) ? mb_if.rdata : '0;
endmodule
